fifo_read_arbiter: RTL and testbench

Read-side port scheduler for the asynchronous FIFO. Sits in the `r_clk` domain between the read pointer handler and up to `NUM_REQ` consumers. It shares the single FIFO read port among the consumers using round-robin bursts. It drives the pointer handler's read enable from the FIFO `empty` flag and returns the popped data to the granted consumer, tagged with that consumer's ID.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_read_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_read_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_read_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default widths and the
// read/write scheduler state encoding.
package fifo_pkg;

    localparam int PTR_WIDTH  = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned NU = N;

    int unsigned j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            j = 32'(rr_ptr) + i;
            if (j >= NU) begin
                j = j - NU;
            end
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Read-side scheduler: shares the FIFO read port among NUM_REQ consumers
// with round-robin bursts and tags each popped word with its owner's ID.
module fifo_read_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = fifo_pkg::MAX_BURST,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_en,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  owner;
    logic [CNT_W-1:0] cnt;
    logic             pick_any;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W-1:0]  owner_next;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign owner_next = (32'(owner) == NUM_REQ - 1) ? '0 : owner + ID_W'(1);
    assign busy       = (state == ST_BURST);

    always_comb begin
        state_nxt = state;
        r_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any && !empty) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                r_en = req[owner] && !empty;
                if ((r_en && cnt == CNT_W'(MAX_BURST - 1)) || !req[owner] || empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!r_rst) begin
            r_en = 1'b0;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= r_en;
            if (r_en) begin
                out_data <= rdata;
                out_id   <= owner;
            end
            if (state == ST_IDLE && state_nxt == ST_BURST) begin
                owner <= pick_idx;
                gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                cnt   <= '0;
            end else if (state == ST_BURST) begin
                // Exit takes priority over the count so cnt never reaches MAX_BURST.
                if (state_nxt == ST_IDLE) begin
                    rr_ptr <= owner_next;
                    gnt    <= '0;
                    cnt    <= '0;
                end else if (r_en) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: reset, full burst, fairness,
// empty stall, withdraw and reset mid-burst.
module tb_fifo_read_arbiter;

    logic       r_clk;
    logic       r_rst;
    logic [3:0] req;
    logic       empty;
    logic [7:0] rdata;
    logic       r_en;
    logic [3:0] gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    fifo_read_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .req       (req),
        .empty     (empty),
        .rdata     (rdata),
        .r_en      (r_en),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic settle();
        @(negedge r_clk);
    endtask

    task automatic advance();
        @(posedge r_clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic [3:0] g, input logic e, input logic b);
        check_eq({tag, ".gnt"},  32'(gnt),  32'(g));
        check_eq({tag, ".r_en"}, 32'(r_en), 32'(e));
        check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check_eq({tag, ".out_data"}, 32'(out_data), 32'(d));
            check_eq({tag, ".out_id"},   32'(out_id),   32'(id));
        end
    endtask

    task automatic do_reset();
        r_rst = 1'b0;
        req   = '0;
        empty = 1'b0;
        rdata = '0;
        advance();
        r_rst = 1'b1;
    endtask

    int order [3] = '{0, 1, 3};

    initial begin
        r_rst = 1'b0;
        req   = 4'b1111;
        empty = 1'b0;
        rdata = 8'h00;
        advance();

        // Reset held with requests pending
        for (int i = 0; i < 2; i++) begin
            settle();
            expect_ctl("rst", 4'b0000, 1'b0, 1'b0);
            check_eq("rst.out_valid", 32'(out_valid), 32'd0);
            check_eq("rst.out_data",  32'(out_data),  32'd0);
            check_eq("rst.out_id",    32'(out_id),    32'd0);
            advance();
        end
        r_rst = 1'b1;
        settle();
        expect_ctl("rel0", 4'b0000, 1'b0, 1'b0);
        advance();
        settle();
        expect_ctl("rel1", 4'b0001, 1'b1, 1'b1);
        advance();

        // Full burst to consumer 2
        do_reset();
        req = 4'b0100;
        settle();
        expect_ctl("fb.idle", 4'b0000, 1'b0, 1'b0);
        advance();
        for (int k = 0; k < 4; k++) begin
            rdata = 8'hA0 + 8'(k);
            settle();
            expect_ctl("fb.pop", 4'b0100, 1'b1, 1'b1);
            expect_out("fb.pop", k > 0, 8'hA0 + 8'(k - 1), 2'd2);
            advance();
        end
        rdata = 8'hA4;
        req   = 4'b1111;
        settle();
        expect_ctl("fb.end", 4'b0000, 1'b0, 1'b0);
        expect_out("fb.end", 1'b1, 8'hA3, 2'd2);
        advance();
        settle();
        expect_ctl("fb.next", 4'b1000, 1'b1, 1'b1);
        expect_out("fb.next", 1'b0, 8'h00, 2'd0);
        check_eq("fb.hold", 32'(out_data), 32'hA3);
        advance();

        // Round-robin fairness
        do_reset();
        req = 4'b1011;
        for (int b = 0; b < 6; b++) begin
            settle();
            expect_ctl("rr.idle", 4'b0000, 1'b0, 1'b0);
            if (b > 0) begin
                check_eq("rr.gap_valid", 32'(out_valid), 32'd1);
                check_eq("rr.gap_id",    32'(out_id),    32'(order[(b + 2) % 3]));
            end
            advance();
            for (int k = 0; k < 4; k++) begin
                rdata = 8'(16 * b + k);
                settle();
                expect_ctl("rr.pop", 4'b0001 << order[b % 3], 1'b1, 1'b1);
                if (k > 0) begin
                    expect_out("rr.pop", 1'b1, 8'(16 * b + k - 1), 2'(order[b % 3]));
                end
                advance();
            end
        end

        // Empty stall after two pops to consumer 1
        do_reset();
        req = 4'b0010;
        advance();
        rdata = 8'hB0;
        settle();
        expect_ctl("es.pop0", 4'b0010, 1'b1, 1'b1);
        advance();
        rdata = 8'hB1;
        settle();
        expect_ctl("es.pop1", 4'b0010, 1'b1, 1'b1);
        expect_out("es.pop1", 1'b1, 8'hB0, 2'd1);
        advance();
        empty = 1'b1;
        rdata = 8'hEE;
        settle();
        expect_ctl("es.stall", 4'b0010, 1'b0, 1'b1);
        expect_out("es.stall", 1'b1, 8'hB1, 2'd1);
        advance();
        for (int i = 0; i < 2; i++) begin
            settle();
            expect_ctl("es.wait", 4'b0000, 1'b0, 1'b0);
            check_eq("es.wait_valid", 32'(out_valid), 32'd0);
            advance();
        end
        empty = 1'b0;
        advance();

        // Withdraw by consumer 3 after one pop
        do_reset();
        req = 4'b1000;
        advance();
        rdata = 8'hC0;
        settle();
        expect_ctl("wd.pop", 4'b1000, 1'b1, 1'b1);
        advance();
        req = 4'b0110;
        settle();
        expect_ctl("wd.drop", 4'b1000, 1'b0, 1'b1);
        expect_out("wd.drop", 1'b1, 8'hC0, 2'd3);
        advance();
        settle();
        expect_ctl("wd.idle", 4'b0000, 1'b0, 1'b0);
        check_eq("wd.idle_valid", 32'(out_valid), 32'd0);
        advance();
        settle();
        expect_ctl("wd.next", 4'b0010, 1'b1, 1'b1);
        advance();

        // Reset in the cycle after the second pop
        do_reset();
        req = 4'b0100;
        advance();
        for (int k = 0; k < 2; k++) begin
            rdata = 8'hD0 + 8'(k);
            settle();
            expect_ctl("rm.pop", 4'b0100, 1'b1, 1'b1);
            advance();
        end
        r_rst = 1'b0;
        settle();
        check_eq("rm.forced_ren", 32'(r_en), 32'd0);
        expect_out("rm.inflight", 1'b1, 8'hD1, 2'd2);
        advance();
        r_rst = 1'b1;
        req   = 4'b1100;
        settle();
        expect_ctl("rm.after", 4'b0000, 1'b0, 1'b0);
        check_eq("rm.after_valid", 32'(out_valid), 32'd0);
        check_eq("rm.after_data",  32'(out_data),  32'd0);
        advance();
        settle();
        expect_ctl("rm.regrant", 4'b0100, 1'b1, 1'b1);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
